// File: rtl/hazard_fwd_unit.sv
// Hazard detection and operand forwarding for a five-stage pipeline with a
// multi-cycle mul/div unit (MDU).
//
// MDU FSM states
//   state | meaning
//   IDLE  | no mul/div in flight; a new op may issue from EX
//   BUSY  | mul/div in flight; cnt counts the remaining busy cycles down to 0
//
// Ports
//   clk, rst                        clock; synchronous active-high reset
//   rs_d, rt_d                      ID-stage source registers
//   rs_e, rt_e                      EX-stage source registers
//   wr_reg_e/m/w, reg_wr_e/m/w      destination registers and write enables
//   mem_to_reg_e/m                  load in EX / MEM
//   branch_d, branch_taken_d        branch in ID and its resolution
//   mdu_start_e, mdu_use_d          mul/div issue in EX; ID needs the MDU
//   alu_out_m, wb_data_w            forwarding sources
//   rs_data_e, rt_data_e            EX register-file operands
//   rs_fwd_e, rt_fwd_e              forwarded EX operands
//   fwd_rs_e, fwd_rt_e              EX select: 10 MEM, 01 WB, 00 register file
//   fwd_rs_d, fwd_rt_d              ID branch operand taken from alu_out_m
//   stall_f, stall_d, flush_d, flush_e
//   mdu_busy                        FSM is in BUSY
//   stall_cycles                    saturating count of stalled cycles
module hazard_fwd_unit #(
   parameter int DW      = 32,
   parameter int RW      = 5,
   parameter int MDU_LAT = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [RW-1:0] rs_d,
   input  logic [RW-1:0] rt_d,
   input  logic [RW-1:0] rs_e,
   input  logic [RW-1:0] rt_e,
   input  logic [RW-1:0] wr_reg_e,
   input  logic [RW-1:0] wr_reg_m,
   input  logic [RW-1:0] wr_reg_w,
   input  logic          reg_wr_e,
   input  logic          reg_wr_m,
   input  logic          reg_wr_w,
   input  logic          mem_to_reg_e,
   input  logic          mem_to_reg_m,
   input  logic          branch_d,
   input  logic          branch_taken_d,
   input  logic          mdu_start_e,
   input  logic          mdu_use_d,
   input  logic [DW-1:0] alu_out_m,
   input  logic [DW-1:0] wb_data_w,
   input  logic [DW-1:0] rs_data_e,
   input  logic [DW-1:0] rt_data_e,
   output logic [DW-1:0] rs_fwd_e,
   output logic [DW-1:0] rt_fwd_e,
   output logic [1:0]    fwd_rs_e,
   output logic [1:0]    fwd_rt_e,
   output logic          fwd_rs_d,
   output logic          fwd_rt_d,
   output logic          stall_f,
   output logic          stall_d,
   output logic          flush_d,
   output logic          flush_e,
   output logic          mdu_busy,
   output logic [15:0]   stall_cycles
);

   localparam logic [3:0] MDU_LOAD = 4'(MDU_LAT - 1);

   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} mdu_state_t;

   mdu_state_t state_q, state_d;
   logic [3:0] cnt_q, cnt_d;

   logic lu_stall, br_stall, mdu_stall, stall;
   logic ld_match_e, wr_match_e, ld_match_m;

   // MEM has priority over WB; r0 is never forwarded.
   function automatic logic [1:0] fwd_sel(input logic [RW-1:0] src,
                                          input logic          wr_m,
                                          input logic [RW-1:0] reg_m,
                                          input logic          wr_w,
                                          input logic [RW-1:0] reg_w);
      logic [1:0] sel;
      sel = 2'b00;
      if (wr_m && (reg_m != '0) && (reg_m == src))
         sel = 2'b10;
      else if (wr_w && (reg_w != '0) && (reg_w == src))
         sel = 2'b01;
      return sel;
   endfunction

   always_comb begin
      fwd_rs_e = fwd_sel(rs_e, reg_wr_m, wr_reg_m, reg_wr_w, wr_reg_w);
      fwd_rt_e = fwd_sel(rt_e, reg_wr_m, wr_reg_m, reg_wr_w, wr_reg_w);
   end

   always_comb begin
      case (fwd_rs_e)
         2'b10:   rs_fwd_e = alu_out_m;
         2'b01:   rs_fwd_e = wb_data_w;
         default: rs_fwd_e = rs_data_e;
      endcase
      case (fwd_rt_e)
         2'b10:   rt_fwd_e = alu_out_m;
         2'b01:   rt_fwd_e = wb_data_w;
         default: rt_fwd_e = rt_data_e;
      endcase
   end

   // A load result in MEM is not available yet, so only ALU results feed
   // the ID branch comparator.
   assign fwd_rs_d = (rs_d != '0) && (rs_d == wr_reg_m) && reg_wr_m && !mem_to_reg_m;
   assign fwd_rt_d = (rt_d != '0) && (rt_d == wr_reg_m) && reg_wr_m && !mem_to_reg_m;

   assign wr_match_e = reg_wr_e && (wr_reg_e != '0) &&
                       ((wr_reg_e == rs_d) || (wr_reg_e == rt_d));
   assign ld_match_e = wr_match_e && mem_to_reg_e;
   assign ld_match_m = mem_to_reg_m && (wr_reg_m != '0) &&
                       ((wr_reg_m == rs_d) || (wr_reg_m == rt_d));

   assign lu_stall  = ld_match_e;
   assign br_stall  = branch_d && (wr_match_e || ld_match_m);
   assign mdu_stall = mdu_use_d && (mdu_start_e || (state_q == BUSY));
   assign stall     = lu_stall || br_stall || mdu_stall;

   // Reset holds the pipeline in a flushed, non-stalled condition.
   assign stall_f  = rst ? 1'b0 : stall;
   assign stall_d  = rst ? 1'b0 : stall;
   assign flush_e  = rst ? 1'b1 : stall;
   assign flush_d  = rst ? 1'b1 : (branch_taken_d && !stall);
   assign mdu_busy = (state_q == BUSY);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (mdu_start_e) begin
               cnt_d   = MDU_LOAD;
               state_d = BUSY;
            end
         end
         BUSY: begin
            // New issues are ignored while an op is in flight.
            if (cnt_q != 4'd0)
               cnt_d = cnt_q - 4'd1;
            else
               state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            cnt_d   = 4'd0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst)
         stall_cycles <= 16'd0;
      else if (stall_f && (stall_cycles != 16'hFFFF))
         stall_cycles <= stall_cycles + 16'd1;
   end

endmodule

// File: doc/hazard_fwd_unit.md
HAZARD_FWD_UNIT -- requirements
Module: hazard_fwd_unit

Interface
REQ-001 Parameter DW, default 32, SHALL set the datapath width of the forwarded operands.
REQ-002 Parameter RW, default 5, SHALL set the register-address width.
REQ-003 Parameter MDU_LAT, default 4, range 1..15, SHALL set the mul/div busy cycles after issue.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst  in  1  reset; synchronous and active-high.
REQ-006 rs_d, rt_d  in  RW  source register numbers of the ID-stage instruction.
REQ-007 rs_e, rt_e  in  RW  source register numbers of the EX-stage instruction.
REQ-008 wr_reg_e, wr_reg_m, wr_reg_w  in  RW  destination register numbers in EX, MEM and WB.
REQ-009 reg_wr_e, reg_wr_m, reg_wr_w  in  1  register-write enables in EX, MEM and WB.
REQ-010 mem_to_reg_e, mem_to_reg_m  in  1  the instruction in EX or MEM is a load.
REQ-011 branch_d, branch_taken_d  in  1  ID holds a branch; that branch resolves as taken.
REQ-012 mdu_start_e  in  1  a mul/div op issues in EX this cycle.
REQ-013 mdu_use_d  in  1  the ID instruction reads HI/LO or is itself a mul/div op.
REQ-014 alu_out_m, wb_data_w, rs_data_e, rt_data_e  in  DW  MEM ALU result, WB write data, and the EX register-file operands.
REQ-015 rs_fwd_e, rt_fwd_e  out  DW  forwarded EX operands.
REQ-016 fwd_rs_e, fwd_rt_e  out  2  EX forward select: 10 = MEM, 01 = WB, 00 = register file.
REQ-017 fwd_rs_d, fwd_rt_d  out  1  ID branch-compare operand taken from alu_out_m.
REQ-018 stall_f, stall_d, flush_d, flush_e  out  1  PC hold, IF/ID hold, IF/ID clear, ID/EX bubble.
REQ-019 mdu_busy  out  1  the MDU FSM is in BUSY.
REQ-020 stall_cycles  out  16  count of cycles with stall_f = 1.

Function
REQ-021 fwd_rs_e SHALL be 10 when reg_wr_m = 1, wr_reg_m != 0 and wr_reg_m == rs_e.
REQ-022 Otherwise fwd_rs_e SHALL be 01 when reg_wr_w = 1, wr_reg_w != 0 and wr_reg_w == rs_e; otherwise 00.
REQ-023 fwd_rt_e SHALL follow the same rules as fwd_rs_e, using rt_e in place of rs_e.
REQ-024 MEM SHALL take priority over WB whenever both match.
REQ-025 rs_fwd_e and rt_fwd_e SHALL be combinational muxes driven by their selects.
REQ-026 fwd_rs_d SHALL be 1 when rs_d != 0, rs_d == wr_reg_m, reg_wr_m = 1 and mem_to_reg_m = 0; fwd_rt_d likewise, using rt_d.
REQ-027 lu_stall SHALL be 1 when reg_wr_e = 1, mem_to_reg_e = 1, wr_reg_e != 0 and wr_reg_e matches rs_d or rt_d.
REQ-028 br_stall SHALL be 1 when branch_d = 1 and either (reg_wr_e = 1, wr_reg_e != 0, matching rs_d or rt_d) or (mem_to_reg_m = 1, wr_reg_m != 0, matching rs_d or rt_d).
REQ-029 MDU FSM states SHALL be IDLE and BUSY, with a 4-bit counter cnt.
REQ-030 In IDLE, mdu_start_e = 1 SHALL load cnt <= MDU_LAT-1 and move the FSM to BUSY.
REQ-031 In BUSY with cnt != 0, cnt SHALL decrement each cycle.
REQ-032 In BUSY with cnt == 0, the FSM SHALL return to IDLE on the next edge.
REQ-033 mdu_start_e asserted during BUSY SHALL be ignored.
REQ-034 mdu_stall SHALL be 1 when mdu_use_d = 1 and (mdu_start_e = 1 or the FSM is in BUSY).
REQ-035 With stall = lu_stall | br_stall | mdu_stall, stall_f and stall_d SHALL equal stall, and flush_e SHALL equal stall.
REQ-036 flush_d SHALL equal branch_taken_d & ~stall, so a stalled branch never flushes.
REQ-037 stall_cycles SHALL increment on each edge with stall_f = 1 and saturate at 16'hFFFF.

Reset
REQ-038 On any edge with rst = 1, FSM = IDLE, cnt = 0, stall_cycles = 0, and mdu_busy = 0 from the next cycle.
REQ-039 While rst = 1, stall_f = stall_d = 0 and flush_d = flush_e = 1.
REQ-040 Asserting rst during BUSY SHALL abort the MDU operation, with no stall in the cycle after rst deasserts.

Verification
REQ-041 EX rs_e = 8; M writes r8 with alu_out_m = 32'hAAAA0000; W writes r8 with wb_data_w = 32'h5555 -> fwd_rs_e = 10, rs_fwd_e = 32'hAAAA0000.
REQ-042 Writes to r0 in M and W with rs_e = 0 and rs_data_e = 0 -> fwd_rs_e = 00, rs_fwd_e = 0, no stall.
REQ-043 Load in EX to r3 with rt_d = 3 -> one cycle with stall_f = stall_d = flush_e = 1, then 0; stall_cycles = 1.
REQ-044 MDU_LAT = 4, mdu_start_e at cycle 0, mdu_use_d held high -> stall for cycles 0..4; mdu_busy high for cycles 1..4; FSM IDLE at cycle 5; stall_cycles = 5.
REQ-045 branch_d = branch_taken_d = 1 with ALU writer r4 in EX and rs_d = 4 -> cycle 0 stall = 1 and flush_d = 0; cycle 1 (writer in M) fwd_rs_d = 1 and flush_d = 1.
REQ-046 Hold stall for 70000 cycles -> stall_cycles = 16'hFFFF; rst pulse during BUSY -> mdu_busy = 0 next cycle and stall_cycles = 0.
